// File: rtl/uart_tx_arb.sv
// ============================================================================
// Module  : uart_tx_arb
// Brief   : Round-robin arbiter/sequencer sharing one UART transmitter among
//           NUM_REQ byte producers, with optional per-message burst locking.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arb #(
    parameter int NUM_REQ  = 4,
    parameter int SEL_W    = $clog2(NUM_REQ),
    parameter int START_TO = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     ack,
    output logic                   trmt,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   busy,
    output logic [SEL_W-1:0]       cur_src,
    output logic                   locked,
    output logic                   err
);

    localparam int c_CNT_W = $clog2(START_TO + 1);

    localparam logic [1:0] c_IDLE       = 2'd0;
    localparam logic [1:0] c_LAUNCH     = 2'd1;
    localparam logic [1:0] c_WAIT_START = 2'd2;
    localparam logic [1:0] c_WAIT_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_cur_src;
    logic [7:0]         r_tx_data;
    logic               r_locked;
    logic               r_err;
    logic [c_CNT_W-1:0] r_to_cnt;

    logic [NUM_REQ-1:0] w_elig;
    logic [SEL_W-1:0]   w_cand;
    logic [SEL_W-1:0]   w_win_idx;
    logic               w_win_vld;
    logic [SEL_W-1:0]   w_src_inc;
    logic               w_to_hit;
    logic               w_launch;

    // While a message is in progress only its owner may be granted.
    assign w_elig    = r_locked ? (req & (NUM_REQ'(1) << r_cur_src)) : req;
    assign w_src_inc = (r_cur_src == SEL_W'(NUM_REQ - 1)) ? '0 : r_cur_src + 1'b1;
    assign w_to_hit  = (r_to_cnt == c_CNT_W'(START_TO - 1));
    assign w_launch  = (r_state == c_IDLE) && tx_done && w_win_vld;

    // Scan downward so the candidate closest to ptr overwrites the others.
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = '0;
        w_cand    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_cand = SEL_W'((int'(r_ptr) + k) % NUM_REQ);
            if (w_elig[w_cand]) begin
                w_win_vld = 1'b1;
                w_win_idx = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_launch) begin
                    w_state_nxt = c_LAUNCH;
                end
            end
            c_LAUNCH: begin
                w_state_nxt = c_WAIT_START;
            end
            c_WAIT_START: begin
                if (!tx_done) begin
                    w_state_nxt = c_WAIT_DONE;
                end else if (w_to_hit) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_WAIT_DONE: begin
                if (tx_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_comb begin
        trmt = (r_state == c_LAUNCH);
        busy = (r_state != c_IDLE);
        ack  = '0;
        if (r_state == c_LAUNCH) begin
            ack = NUM_REQ'(1) << r_cur_src;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr     <= '0;
            r_cur_src <= '0;
            r_tx_data <= 8'h00;
            r_locked  <= 1'b0;
            r_err     <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_launch) begin
                        r_tx_data <= req_data[{w_win_idx, 3'b000} +: 8];
                        r_cur_src <= w_win_idx;
                        r_locked  <= ~req_last[w_win_idx];
                    end
                end
                c_LAUNCH: begin
                    r_to_cnt <= '0;
                end
                c_WAIT_START: begin
                    // Transmitter never acknowledged the strobe: abandon the message.
                    if (tx_done) begin
                        if (w_to_hit) begin
                            r_err    <= 1'b1;
                            r_locked <= 1'b0;
                            r_ptr    <= w_src_inc;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                end
                c_WAIT_DONE: begin
                    if (tx_done && !r_locked) begin
                        r_ptr <= w_src_inc;
                    end
                end
                default: begin
                    r_to_cnt <= '0;
                end
            endcase
        end
    end

    assign tx_data = r_tx_data;
    assign cur_src = r_cur_src;
    assign locked  = r_locked;
    assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// ============================================================================
// Module  : tb_uart_tx_arb
// Brief   : Self-checking bench for uart_tx_arb: requester queues, transmitter
//           model and a message-level round-robin reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arb;

    localparam int N   = 4;
    localparam int SW  = 2;
    localparam int STO = 8;
    localparam int QD  = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic           tx_done = 1'b1;
    logic [N-1:0]   ack;
    logic           trmt;
    logic [7:0]     tx_data;
    logic           busy;
    logic [SW-1:0]  cur_src;
    logic           locked;
    logic           err;

    uart_tx_arb #(.NUM_REQ(N), .SEL_W(SW), .START_TO(STO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .ack(ack), .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done), .busy(busy),
        .cur_src(cur_src), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Requester message queues; e_head is how far the reference has consumed.
    logic [7:0] p_data[N][QD];
    bit         p_last[N][QD];
    int         p_dly[N][QD];
    int         p_head[N];
    int         p_cnt[N];
    int         e_head[N];
    int         wt[N];

    logic [7:0] exp_data[1024];
    int         exp_src[1024];
    bit         exp_last[1024];
    int         exp_n = 0;
    int         exp_idx = 0;
    int         m_ptr = 0;

    bit tx_respond = 1'b1;
    int tx_len_force = 0;
    int st_cnt = 0;
    int bz_cnt = 0;
    int bz_len = 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic load_pkt(input int i, input logic [7:0] d, input bit last, input int dly);
        p_data[i][p_cnt[i]] = d;
        p_last[i][p_cnt[i]] = last;
        p_dly[i][p_cnt[i]]  = dly;
        p_cnt[i]++;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < N; i++) begin
            p_head[i] = 0; p_cnt[i] = 0; e_head[i] = 0; wt[i] = 0;
        end
    endtask

    // Reference: whole messages granted round-robin among non-empty queues.
    task automatic build_expect();
        int  src;
        bit  last;
        forever begin
            src = -1;
            for (int k = N - 1; k >= 0; k--)
                if (e_head[(m_ptr + k) % N] < p_cnt[(m_ptr + k) % N]) src = (m_ptr + k) % N;
            if (src < 0) break;
            last = 1'b0;
            while (!last && e_head[src] < p_cnt[src]) begin
                last = p_last[src][e_head[src]];
                exp_data[exp_n] = p_data[src][e_head[src]];
                exp_src[exp_n]  = src;
                exp_last[exp_n] = last;
                exp_n++;
                e_head[src]++;
            end
            if (!last) break;
            m_ptr = (src + 1) % N;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
    endtask

    task automatic wait_drain(input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            @(negedge clk);
            ok = (exp_idx == exp_n) && !busy && tx_done;
            for (int i = 0; i < N; i++) if (p_head[i] != p_cnt[i]) ok = 1'b0;
        end
        check_val(tag, ok, 1);
    endtask

    task automatic wait_trmt(input string tag);
        bit ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            ok = trmt;
        end
        check_val(tag, ok, 1);
    endtask

    // Per-cycle agent: scoreboard, transmitter model, requester drivers.
    initial begin
        clear_queues();
        forever begin
            @(negedge clk);
            if (trmt) begin
                if (exp_idx < exp_n) begin
                    check_val("tx_data", tx_data, exp_data[exp_idx]);
                    check_val("cur_src", cur_src, exp_src[exp_idx]);
                    check_val("ack", ack, 1 << exp_src[exp_idx]);
                    check_val("locked", locked, !exp_last[exp_idx]);
                    exp_idx++;
                end else begin
                    check_val("extra_trmt", trmt, 0);
                end
            end else begin
                check_val("ack_idle", ack, 0);
            end

            if (st_cnt > 0) begin
                st_cnt--;
                if (st_cnt == 0) begin
                    tx_done = 1'b0;
                    bz_cnt  = bz_len;
                end
            end else if (bz_cnt > 0) begin
                bz_cnt--;
                if (bz_cnt == 0) tx_done = 1'b1;
            end
            if (trmt && tx_respond) begin
                st_cnt = $urandom_range(1, 3);
                bz_len = (tx_len_force > 0) ? tx_len_force : $urandom_range(1, 6);
            end

            for (int i = 0; i < N; i++) begin
                if (ack[i] && p_head[i] < p_cnt[i]) begin
                    p_head[i]++;
                    wt[i] = (p_head[i] < p_cnt[i]) ? p_dly[i][p_head[i]] : 0;
                end else if (wt[i] > 0) begin
                    wt[i]--;
                end
                if (p_head[i] < p_cnt[i] && wt[i] == 0) begin
                    req[i]          = 1'b1;
                    req_data[8*i+:8] = p_data[i][p_head[i]];
                    req_last[i]     = p_last[i][p_head[i]];
                end else begin
                    req[i]          = 1'b0;
                    req_data[8*i+:8] = 8'($urandom);
                    req_last[i]     = 1'($urandom);
                end
            end
        end
    end

    initial begin
        int k;
        int nm;
        int len;

        // Reset values, then a single request from requester 2.
        do_reset();
        check_val("rst_trmt", trmt, 0);
        check_val("rst_ack", ack, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_locked", locked, 0);
        check_val("rst_err", err, 0);
        check_val("rst_cur_src", cur_src, 0);
        check_val("rst_tx_data", tx_data, 0);
        clear_queues();
        load_pkt(2, 8'hA5, 1'b1, 0);
        build_expect();
        wait_drain("single_drain");
        // ptr now 3: requester 3 must beat requester 0.
        load_pkt(0, 8'hB0, 1'b1, 0);
        load_pkt(3, 8'hB3, 1'b1, 0);
        build_expect();
        wait_drain("ptr_after_single");

        // Fairness: all four requesting continuously.
        do_reset();
        clear_queues();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) load_pkt(i, 8'(8'h10 + i), 1'b1, 0);
        build_expect();
        wait_drain("fair_drain");

        // Burst lock: 3-byte message from requester 1 while 3 waits.
        do_reset();
        clear_queues();
        load_pkt(1, 8'h31, 1'b0, 0);
        load_pkt(1, 8'h32, 1'b0, 0);
        load_pkt(1, 8'h33, 1'b1, 0);
        load_pkt(3, 8'h77, 1'b1, 0);
        build_expect();
        wait_drain("burst_drain");

        // Lock stall: requester 0 goes quiet mid-message for 50 cycles.
        do_reset();
        clear_queues();
        load_pkt(0, 8'h41, 1'b0, 0);
        load_pkt(0, 8'h42, 1'b1, 50);
        load_pkt(2, 8'h61, 1'b1, 0);
        build_expect();
        wait_drain("stall_drain");

        // Start timeout with a silent transmitter.
        do_reset();
        clear_queues();
        tx_respond = 1'b0;
        load_pkt(1, 8'h55, 1'b0, 0);
        build_expect();
        wait_trmt("to_launch");
        for (k = 1; k <= STO + 4; k++) begin
            @(negedge clk);
            if (err) break;
        end
        check_val("to_latency", k, STO + 1);
        check_val("to_locked", locked, 0);
        check_val("to_busy", busy, 0);
        tx_respond = 1'b1;
        m_ptr = 2;
        load_pkt(3, 8'h99, 1'b1, 0);
        build_expect();
        wait_drain("to_next_served");
        check_val("err_sticky", err, 1);
        do_reset();
        check_val("err_cleared", err, 0);

        // Reset while the transmitter is mid-byte.
        clear_queues();
        tx_len_force = 30;
        load_pkt(0, 8'hC1, 1'b1, 0);
        build_expect();
        wait_trmt("mr_launch");
        for (int c = 0; c < 20 && tx_done; c++) @(negedge clk);
        repeat (3) @(negedge clk);
        load_pkt(2, 8'hC2, 1'b1, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        check_val("mr_busy", busy, 0);
        check_val("mr_trmt", trmt, 0);
        check_val("mr_ack", ack, 0);
        check_val("mr_cur_src", cur_src, 0);
        check_val("mr_tx_data", tx_data, 0);
        build_expect();
        for (int c = 0; c < 60 && !tx_done; c++) begin
            check_val("mr_hold", trmt, 0);
            @(negedge clk);
        end
        tx_len_force = 0;
        wait_drain("mr_drain");

        // Randomized messages with in-message gaps.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            clear_queues();
            for (int i = 0; i < N; i++) begin
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++)
                        load_pkt(i, 8'($urandom), (b == len - 1), (b == 0) ? 0 : $urandom_range(0, 4));
                end
            end
            build_expect();
            wait_drain("rand_drain");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
